clint_ctrl: RTL and testbench
=============================

# clint_ctrl

Memory-mapped controller for the core-local interruptor: owns `mtime`, `mtimecmp` and `msip`, and exposes them to the LSU over a single-outstanding valid/ready request/response port. It sequences timer ticking through a prescaler, byte-masked register writes and read-back, and drives the timer and software interrupt lines into the CSR/trap logic. It replaces direct `mtimecmp` write-enable wiring from the execute stage with a bus-visible register block.

## Interface
- `BASE`, 32'h0200_0000, region base address; region size 64 KiB.
- `TICK_DIV`, 1, core cycles per `mtime` increment; legal range ≥1.
- `clk`  in  1  core clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller accepts request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  64  write data.
- `req_wmask`  in  8  byte enables; bit i covers `wdata[8i+7:8i]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  requester accepts response.
- `resp_rdata`  out  64  read data; 0 for writes and errors.
- `resp_err`  out  1  unmapped or misaligned access.
- `MIE`, `MTIE`, `MSIE`  in  1 each  mstatus.MIE, mie.MTIE, mie.MSIE.
- `tint`  out  1  machine timer interrupt request.
- `sint`  out  1  machine software interrupt request.

## Operation
- Register map (offset from `BASE`, `addr[2:0]` must be 0):
  - 0x0000 `msip`: bit 0 writable; other bits read 0.
  - 0x4000 `mtimecmp`: 64-bit read/write.
  - 0xBFF8 `mtime`: 64-bit read/write.
- Any other offset, address outside the region, or `addr[2:0]`≠0: `resp_err`=1, `resp_rdata`=0, no state change.
- Write: each register byte is replaced where `req_wmask` bit is set; unmasked bytes unchanged. `wmask`=0 is a legal no-op write.
- Read: `resp_rdata` is the register value in the acceptance cycle, frozen until the response handshake completes.
- FSM: IDLE — `req_ready`=1; on `req_valid` perform access, go RESP. RESP — `req_ready`=0, `resp_valid`=1; on `resp_ready` go IDLE. No other states.
- Prescaler: counter 0..`TICK_DIV`-1; `mtime` increments by 1 when counter = `TICK_DIV`-1, counter wraps to 0. `TICK_DIV`=1 increments every cycle.
- `mtime` wraps 2^64-1 → 0 with no flag.
- Bus write to `mtime` in a tick cycle: written value wins, tick discarded; prescaler counter unaffected.
- `tint` = (`mtime` ≥ `mtimecmp`, unsigned 64-bit) & `MIE` & `MTIE`; `sint` = `msip` & `MIE` & `MSIE`. Both are combinational from registered state plus enable inputs.

## Timing
- Reset values: `mtime`=0, prescaler=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, FSM=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `tint`=0, `sint`=0.
- Access latency: request accepted in cycle N; register updated at end of N; `resp_valid` high from N+1.
- Maximum throughput is one access per 2 cycles. Requests are held off by `req_ready`=0 in RESP.
- Write effects on `tint`/`sint` are visible from cycle N+1, the same cycle as `resp_valid`.
- `tint` asserts the cycle after the tick that makes `mtime` ≥ `mtimecmp`. Enable-input changes take effect in the same cycle.
- `rst` asserted in RESP drops the pending response. `resp_valid` is 0 the next cycle, and the requester must not expect completion.
- `resp_*` remain stable while `resp_valid`=1 and `resp_ready`=0.

## Structure
- Package `clint_pkg`: offset constants `MSIP_OFF`, `MTIMECMP_OFF`, `MTIME_OFF`; default `BASE`; FSM state enum `{IDLE, RESP}`.
- Sub-module `clint_timer`: prescaler and `mtime` register with tick, masked write port and compare output `mtime_ge`. `clint_ctrl` holds decode, FSM, `mtimecmp`, `msip` and the interrupt gating.

## Test plan
- Reset, then read 0xBFF8 after 10 idle cycles with `TICK_DIV`=1 → `resp_rdata` equals the `mtime` value at the acceptance cycle (≈10), `resp_err`=0; read 0x4000 → all ones.
- Write `mtimecmp`=20, `MIE`=`MTIE`=1 → `tint` rises exactly in the cycle after `mtime` becomes 20; write `mtimecmp`=all ones → `tint` drops the cycle after acceptance.
- Write 0xBFF8 with `wmask`=8'h0F, data 64'h1111_2222_3333_4444 while `mtime`=0x5 → `mtime`=0x0000_0000_3333_4444, and the write wins over a coincident tick.
- `TICK_DIV`=4 → `mtime` advances by 1 every 4 cycles; preload `mtime`=2^64-1 → wraps to 0.
- Read 0x0008 and 0x4004 → `resp_err`=1, `resp_rdata`=0, no register change. Write `msip`=1 with `MSIE`=0 → `sint`=0; then raise `MSIE` → `sint`=1 in the same cycle.
- Hold `resp_ready`=0 for 5 cycles → `resp_*` stable and `req_ready`=0; assert `rst` in RESP → `resp_valid`=0 next cycle, registers at reset values.

Source files
------------

// File: rtl/clint_pkg.sv
// clint_pkg: shared constants and types for the core-local interruptor.
//   DEFAULT_BASE             default region base address (64 KiB region)
//   MSIP_OFF/MTIMECMP_OFF/MTIME_OFF  register offsets within the region
//   state_t                  bus FSM states
//   byte_merge()             byte-masked register update helper
package clint_pkg;

    localparam logic [31:0] DEFAULT_BASE = 32'h0200_0000;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    // Replace each byte of i_old whose mask bit is set with the byte of i_new.
    function automatic logic [63:0] byte_merge(input logic [63:0] i_old,
                                               input logic [63:0] i_new,
                                               input logic [7:0]  i_mask);
        logic [63:0] v;
        v = i_old;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i_mask[i]) begin
                v[8*i +: 8] = i_new[8*i +: 8];
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// clint_timer: prescaler plus the 64-bit mtime register.
//   clk, rst        core clock, synchronous active-high reset
//   i_we            bus write strobe for mtime (already decoded)
//   i_wdata/i_wmask write data and byte enables
//   i_cmp           current mtimecmp value
//   o_mtime         current mtime value
//   o_mtime_ge      mtime >= mtimecmp (unsigned)
module clint_timer
    import clint_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [63:0] i_wdata,
    input  logic [7:0]  i_wmask,
    input  logic [63:0] i_cmp,
    output logic [63:0] o_mtime,
    output logic        o_mtime_ge
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_presc;
    logic [63:0]   r_mtime;
    logic          w_tick;

    assign w_tick = (r_presc == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_mtime <= '0;
        end else begin
            // Prescaler keeps running regardless of bus writes.
            r_presc <= w_tick ? '0 : r_presc + CW'(1);
            // A write with at least one byte enabled overrides a coincident
            // tick; an all-zero mask is a pure no-op and lets the tick through.
            if (i_we && (|i_wmask)) begin
                r_mtime <= byte_merge(r_mtime, i_wdata, i_wmask);
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtime_ge = (r_mtime >= i_cmp);

endmodule

// File: rtl/clint_ctrl.sv
// clint_ctrl: memory-mapped CLINT register block (msip, mtimecmp, mtime)
// with a single-outstanding valid/ready request/response port.
//   clk, rst                       core clock, synchronous active-high reset
//   req_valid/req_ready            request handshake
//   req_we/req_addr/req_wdata/req_wmask  request payload
//   resp_valid/resp_ready          response handshake
//   resp_rdata/resp_err            read data (0 for writes/errors), error flag
//   MIE, MTIE, MSIE                interrupt enable inputs
//   tint, sint                     timer / software interrupt requests
module clint_ctrl
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE     = DEFAULT_BASE,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    input  logic        MIE,
    input  logic        MTIE,
    input  logic        MSIE,
    output logic        tint,
    output logic        sint
);

    state_t      r_state;
    state_t      w_state_next;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [63:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_in_region;
    logic        w_aligned;
    logic        w_sel_msip;
    logic        w_sel_cmp;
    logic        w_sel_mtime;
    logic        w_err;
    logic [63:0] w_rd_value;
    logic [63:0] w_mtime;
    logic        w_mtime_ge;
    logic        w_mtime_we;

    // Address decode
    assign w_in_region = (req_addr[31:16] == BASE[31:16]);
    assign w_aligned   = (req_addr[2:0] == 3'b000);
    assign w_sel_msip  = w_in_region && w_aligned && (req_addr[15:0] == MSIP_OFF);
    assign w_sel_cmp   = w_in_region && w_aligned && (req_addr[15:0] == MTIMECMP_OFF);
    assign w_sel_mtime = w_in_region && w_aligned && (req_addr[15:0] == MTIME_OFF);
    assign w_err       = !(w_sel_msip || w_sel_cmp || w_sel_mtime);

    assign w_accept    = (r_state == IDLE) && req_valid;
    assign w_mtime_we  = w_accept && req_we && w_sel_mtime;

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_mtime_we),
        .i_wdata    (req_wdata),
        .i_wmask    (req_wmask),
        .i_cmp      (r_mtimecmp),
        .o_mtime    (w_mtime),
        .o_mtime_ge (w_mtime_ge)
    );

    // Read mux; writes and errors return zero.
    always_comb begin
        w_rd_value = '0;
        if (!req_we) begin
            if (w_sel_msip) begin
                w_rd_value = {63'd0, r_msip};
            end else if (w_sel_cmp) begin
                w_rd_value = r_mtimecmp;
            end else if (w_sel_mtime) begin
                w_rd_value = w_mtime;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtimecmp <= '1;
            r_msip     <= 1'b0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_rd_value;
            r_err   <= w_err;
            if (req_we && w_sel_cmp) begin
                r_mtimecmp <= byte_merge(r_mtimecmp, req_wdata, req_wmask);
            end
            if (req_we && w_sel_msip && req_wmask[0]) begin
                r_msip <= req_wdata[0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    assign tint = w_mtime_ge && MIE && MTIE;
    assign sint = r_msip && MIE && MSIE;

endmodule

// File: tb/tb_clint_ctrl.sv
// tb_clint_ctrl: self-checking bench. Two instances (TICK_DIV=1 and 4) share
// all inputs; a cycle-level reference model derived from the register rules
// predicts every output, with directed scenarios followed by random traffic.
module tb_clint_ctrl;

    localparam logic [31:0] BASE = 32'h0200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        resp_ready;
    logic        MIE, MTIE, MSIE;

    logic        w_req_ready  [2];
    logic        w_resp_valid [2];
    logic [63:0] w_resp_rdata [2];
    logic        w_resp_err   [2];
    logic        w_tint       [2];
    logic        w_sint       [2];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    clint_ctrl #(.BASE(BASE), .TICK_DIV(1)) u_div1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(w_req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(w_resp_valid[0]), .resp_ready(resp_ready),
        .resp_rdata(w_resp_rdata[0]), .resp_err(w_resp_err[0]),
        .MIE(MIE), .MTIE(MTIE), .MSIE(MSIE),
        .tint(w_tint[0]), .sint(w_sint[0])
    );

    clint_ctrl #(.BASE(BASE), .TICK_DIV(4)) u_div4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(w_req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .resp_valid(w_resp_valid[1]), .resp_ready(resp_ready),
        .resp_rdata(w_resp_rdata[1]), .resp_err(w_resp_err[1]),
        .MIE(MIE), .MTIE(MTIE), .MSIE(MSIE),
        .tint(w_tint[1]), .sint(w_sint[1])
    );

    // ---------------- reference model ----------------
    logic [63:0] m_mtime [2];
    logic [63:0] m_cmp   [2];
    logic        m_msip  [2];
    logic [63:0] m_rdata [2];
    logic        m_err;
    logic        m_pend;
    int unsigned m_ncyc;
    logic [63:0] m_nxt;
    int          m_code;

    function automatic int unsigned div_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // 0 = msip, 1 = mtimecmp, 2 = mtime, 3 = error
    function automatic int decode(input logic [31:0] a);
        if (a[31:16] != BASE[31:16]) return 3;
        if (a[2:0] != 3'b000) return 3;
        if (a[15:0] == 16'h0000) return 0;
        if (a[15:0] == 16'h4000) return 1;
        if (a[15:0] == 16'hBFF8) return 2;
        return 3;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d,
                                          input logic [7:0] m);
        logic [63:0] v;
        v = o;
        for (int i = 0; i < 8; i++) if (m[i]) v[8*i +: 8] = d[8*i +: 8];
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_mtime[k] = 64'd0;
                m_cmp[k]   = {64{1'b1}};
                m_msip[k]  = 1'b0;
                m_rdata[k] = 64'd0;
            end
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_ncyc = 0;
        end else begin
            m_code = decode(req_addr);
            for (int k = 0; k < 2; k++) begin
                m_nxt = ((m_ncyc % div_of(k)) == div_of(k) - 1) ? m_mtime[k] + 64'd1 : m_mtime[k];
                if (!m_pend && req_valid) begin
                    if (req_we || m_code == 3) m_rdata[k] = 64'd0;
                    else if (m_code == 0) m_rdata[k] = {63'd0, m_msip[k]};
                    else if (m_code == 1) m_rdata[k] = m_cmp[k];
                    else m_rdata[k] = m_mtime[k];
                    if (req_we) begin
                        if (m_code == 0 && req_wmask[0]) m_msip[k] = req_wdata[0];
                        if (m_code == 1) m_cmp[k] = merge(m_cmp[k], req_wdata, req_wmask);
                        if (m_code == 2 && req_wmask != 8'h00)
                            m_nxt = merge(m_mtime[k], req_wdata, req_wmask);
                    end
                end
                m_mtime[k] = m_nxt;
            end
            if (!m_pend && req_valid) begin
                m_pend = 1'b1;
                m_err  = (m_code == 3);
            end else if (m_pend && resp_ready) begin
                m_pend = 1'b0;
            end
            m_ncyc++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("req_ready[%0d]", k),  {63'd0, w_req_ready[k]},  {63'd0, !m_pend});
            chk($sformatf("resp_valid[%0d]", k), {63'd0, w_resp_valid[k]}, {63'd0, m_pend});
            chk($sformatf("tint[%0d]", k), {63'd0, w_tint[k]},
                {63'd0, (m_mtime[k] >= m_cmp[k]) && MIE && MTIE});
            chk($sformatf("sint[%0d]", k), {63'd0, w_sint[k]},
                {63'd0, m_msip[k] && MIE && MSIE});
            if (m_pend) begin
                chk($sformatf("rdata[%0d]", k), w_resp_rdata[k], m_rdata[k]);
                chk($sformatf("err[%0d]", k), {63'd0, w_resp_err[k]}, {63'd0, m_err});
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    // One complete access from IDLE; hold = cycles resp_ready stays low.
    task automatic bus(input logic we, input logic [31:0] a, input logic [63:0] d,
                       input logic [7:0] m, input int unsigned hold,
                       output logic [63:0] rd0, output logic [63:0] rd1, output logic e);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d; req_wmask = m;
        resp_ready = 1'b0;
        step();
        req_valid = 1'b0;
        chk("accepted", {63'd0, w_resp_valid[0]}, 64'd1);
        rd0 = w_resp_rdata[0];
        rd1 = w_resp_rdata[1];
        e   = w_resp_err[0];
        for (int unsigned i = 0; i < hold; i++) begin
            step();
            chk("hold_rdata", w_resp_rdata[0], rd0);
            chk("hold_req_ready", {63'd0, w_req_ready[0]}, 64'd0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    logic [31:0] addrs [8];
    logic [63:0] rd0, rd1;
    logic        e;
    int unsigned waited;

    initial begin
        addrs[0] = BASE;               addrs[1] = BASE + 32'h4000;
        addrs[2] = BASE + 32'hBFF8;    addrs[3] = BASE + 32'h0008;
        addrs[4] = BASE + 32'h4004;    addrs[5] = 32'h0300_4000;
        addrs[6] = BASE + 32'hBFFC;    addrs[7] = BASE + 32'h1000;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;
        MIE = 1'b0; MTIE = 1'b0; MSIE = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        chk("rst_rdata", w_resp_rdata[0], 64'd0);
        chk("rst_err", {63'd0, w_resp_err[0]}, 64'd0);
        rst = 1'b0;

        // mtime after 10 idle cycles, then mtimecmp reset value
        repeat (10) step();
        bus(1'b0, BASE + 32'hBFF8, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("mtime_10_div1", rd0, 64'd10);
        chk("mtime_10_div4", rd1, 64'd2);
        chk("mtime_10_err", {63'd0, e}, 64'd0);
        bus(1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("mtimecmp_rst", rd0, {64{1'b1}});

        // timer interrupt rise and drop
        MIE = 1'b1; MTIE = 1'b1;
        #1 check_all();
        bus(1'b1, BASE + 32'h4000, 64'd40, 8'hFF, 0, rd0, rd1, e);
        waited = 0;
        while (!w_tint[0] && waited < 60) begin step(); waited++; end
        chk("tint_rise", {63'd0, w_tint[0]}, 64'd1);
        bus(1'b1, BASE + 32'h4000, {64{1'b1}}, 8'hFF, 0, rd0, rd1, e);
        chk("tint_drop", {63'd0, w_tint[0]}, 64'd0);

        // byte-masked mtime write
        bus(1'b1, BASE + 32'hBFF8, 64'd5, 8'hFF, 0, rd0, rd1, e);
        bus(1'b1, BASE + 32'hBFF8, 64'h1111_2222_3333_4444, 8'h0F, 0, rd0, rd1, e);
        bus(1'b0, BASE + 32'hBFF8, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("mask_hi_div1", {32'd0, rd0[63:32]}, 64'd0);
        chk("mask_mid_div1", {48'd0, rd0[31:16]}, 64'h3333);
        chk("mask_mid_div4", {48'd0, rd1[31:16]}, 64'h3333);

        // wrap at 2^64-1
        bus(1'b1, BASE + 32'hBFF8, {64{1'b1}}, 8'hFF, 0, rd0, rd1, e);
        repeat (8) step();
        bus(1'b0, BASE + 32'hBFF8, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("wrap_div1", {63'd0, rd0 < 64'd16}, 64'd1);
        chk("wrap_div4", {63'd0, rd1 < 64'd16}, 64'd1);

        // unmapped / misaligned
        bus(1'b0, BASE + 32'h0008, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("err_0008", {63'd0, e}, 64'd1);
        chk("err_0008_rdata", rd0, 64'd0);
        bus(1'b0, BASE + 32'h4004, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("err_4004", {63'd0, e}, 64'd1);
        chk("err_4004_rdata", rd0, 64'd0);
        bus(1'b1, BASE + 32'h4004, 64'd0, 8'hFF, 0, rd0, rd1, e);
        bus(1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("err_no_change", rd0, {64{1'b1}});

        // software interrupt gating
        MSIE = 1'b0;
        bus(1'b1, BASE, 64'd1, 8'h01, 0, rd0, rd1, e);
        chk("sint_masked", {63'd0, w_sint[0]}, 64'd0);
        MSIE = 1'b1;
        #1;
        chk("sint_same_cycle", {63'd0, w_sint[0]}, 64'd1);
        check_all();

        // long response hold, then reset while in RESP
        bus(1'b0, BASE + 32'h4000, 64'd0, 8'h00, 5, rd0, rd1, e);
        req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'hBFF8;
        step();
        req_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_drop_resp", {63'd0, w_resp_valid[0]}, 64'd0);
        chk("rst_sint", {63'd0, w_sint[0]}, 64'd0);
        bus(1'b0, BASE + 32'h4000, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("rst_mtimecmp", rd0, {64{1'b1}});
        bus(1'b0, BASE, 64'd0, 8'h00, 0, rd0, rd1, e);
        chk("rst_msip", rd0, 64'd0);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 299) == 0);
            req_valid  = $urandom_range(0, 1);
            req_we     = $urandom_range(0, 1);
            req_addr   = addrs[$urandom_range(0, 7)];
            case ($urandom_range(0, 3))
                0: req_wdata = {$urandom, $urandom};
                1: req_wdata = {64{1'b1}} - 64'($urandom_range(0, 20));
                default: req_wdata = 64'($urandom_range(0, 3000));
            endcase
            case ($urandom_range(0, 3))
                0: req_wmask = 8'($urandom);
                1: req_wmask = 8'h00;
                default: req_wmask = 8'hFF;
            endcase
            resp_ready = ($urandom_range(0, 2) != 0);
            MIE  = ($urandom_range(0, 3) != 0);
            MTIE = ($urandom_range(0, 3) != 0);
            MSIE = ($urandom_range(0, 3) != 0);
            #1 check_all();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
